// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, state encoding and opcode classifiers for the ALU sequencer
package alu_ctrl_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [4:0] opcode);
        logic legal;
        case (opcode)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - classifies a request opcode as legal, mul/div, or divide-by-zero
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] b,
    output logic              legal,
    output logic              muldiv,
    output logic              div0
);

    assign legal  = is_legal(opcode);
    assign muldiv = is_muldiv(opcode);
    assign div0   = (opcode == OP_DIV) && (b == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - handshaked multi-cycle front end for the shared combinational ALU
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SIMPLE_LAT = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_opcode,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [4:0]          alu_opcode,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [2*DATA_W-1:0] alu_z,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_hi,
    output logic [DATA_W-1:0]   resp_lo,
    output logic                resp_err,
    output logic                busy
);

    localparam logic [3:0] SIMPLE_CNT = 4'(SIMPLE_LAT - 1);
    localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       err_q;
    logic       muldiv_q;
    logic       dec_legal, dec_muldiv, dec_div0;
    logic       req_err;

    alu_op_decode #(.DATA_W(DATA_W)) u_decode (
        .opcode (req_opcode),
        .b      (req_b),
        .legal  (dec_legal),
        .muldiv (dec_muldiv),
        .div0   (dec_div0)
    );

    assign req_err = !dec_legal || dec_div0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Rejected requests still take one EXEC cycle so errors answer at k+1 like a 1-cycle op.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid)  state_nx = ST_EXEC;
            ST_EXEC: if (cnt == '0)  state_nx = ST_RESP;
            ST_RESP: if (resp_ready) state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt        <= '0;
            err_q      <= 1'b0;
            muldiv_q   <= 1'b0;
            alu_opcode <= OP_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_hi    <= '0;
            resp_lo    <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        err_q    <= req_err;
                        muldiv_q <= dec_muldiv;
                        if (req_err) begin
                            cnt <= '0;
                        end else begin
                            cnt        <= dec_muldiv ? MULDIV_CNT : SIMPLE_CNT;
                            alu_opcode <= req_opcode;
                            alu_a      <= req_a;
                            alu_b      <= req_b;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        resp_lo    <= err_q ? '0 : alu_z[DATA_W-1:0];
                        // Only MUL/DIV own the upper word; anything else there is stale.
                        resp_hi    <= (err_q || !muldiv_q) ? '0 : alu_z[2*DATA_W-1:DATA_W];
                        resp_err   <= err_q;
                        alu_opcode <= OP_NOP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench with behavioural ALU and reference model
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a, alu_b;
    logic [63:0] alu_z;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_hi, resp_lo;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    localparam int SLAT = 1;
    localparam int MLAT = 4;

    alu_op_sequencer #(.DATA_W(32), .SIMPLE_LAT(SLAT), .MULDIV_LAT(MLAT)) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z      (alu_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic [4:0] legal_ops [13] = '{5'b00101, 5'b00110, 5'b00011, 5'b00100, 5'b10000, 5'b01111,
                                   5'b01001, 5'b01010, 5'b01011, 5'b00111, 5'b01000, 5'b10001,
                                   5'b10010};

    // The ALU puts junk in the upper word for 32-bit ops so the controller's masking is exercised.
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] junk;
        int sh;
        junk = ~a ^ 32'h5A5A_0F0F;
        sh   = int'(b[4:0]);
        case (op)
            5'b00101: return {junk, a & b};
            5'b00110: return {junk, a | b};
            5'b00011: return {junk, a + b};
            5'b00100: return {junk, a - b};
            5'b10000: return {32'd0, a} * {32'd0, b};
            5'b01111: return (b == 0) ? 64'd0 : {a % b, a / b};
            5'b01001: return {junk, a >> sh};
            5'b01010: return {junk, 32'($signed(a) >>> sh)};
            5'b01011: return {junk, a << sh};
            5'b00111: return {junk, (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)))};
            5'b01000: return {junk, (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)))};
            5'b10001: return {junk, 32'd0 - a};
            5'b10010: return {junk, ~a};
            default:  return 64'd0;
        endcase
    endfunction

    always_comb alu_z = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic bit op_legal(input logic [4:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request, follows it to the response, holds backpressure for `hold` cycles, consumes.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] hi, output logic [31:0] lo,
                          output logic err);
        bit          e_err, e_md;
        int          e_lat, n, w;
        logic [63:0] z;
        logic [31:0] e_hi, e_lo;
        e_md  = (op == 5'b10000) || (op == 5'b01111);
        e_err = !op_legal(op) || (op == 5'b01111 && b == 0);
        e_lat = e_err ? 1 : (e_md ? MLAT : SLAT);
        z     = alu_fn(op, a, b);
        e_lo  = e_err ? 32'd0 : z[31:0];
        e_hi  = (e_err || !e_md) ? 32'd0 : z[63:32];

        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(posedge clock); #1; w++;
        end
        chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);

        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(posedge clock); #1;
        req_valid  = 1'b0;
        chk("req_ready_after_accept", {63'd0, req_ready}, 64'd0);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);

        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            chk("alu_opcode_exec", {59'd0, alu_opcode}, e_err ? 64'd0 : {59'd0, op});
            if (!e_err) begin
                chk("alu_a_exec", {32'd0, alu_a}, {32'd0, a});
                chk("alu_b_exec", {32'd0, alu_b}, {32'd0, b});
            end
            @(posedge clock); #1; n++;
        end
        chk("latency", 64'(n), 64'(e_lat));
        chk("resp_hi", {32'd0, resp_hi}, {32'd0, e_hi});
        chk("resp_lo", {32'd0, resp_lo}, {32'd0, e_lo});
        chk("resp_err", {63'd0, resp_err}, {63'd0, e_err});
        chk("alu_opcode_resp", {59'd0, alu_opcode}, 64'd0);
        chk("req_ready_resp", {63'd0, req_ready}, 64'd0);

        for (int i = 0; i < hold; i++) begin
            req_valid  = 1'b1;
            req_opcode = 5'b00011;
            req_a      = $urandom;
            req_b      = $urandom;
            @(posedge clock); #1;
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_lo", {32'd0, resp_lo}, {32'd0, e_lo});
            chk("hold_hi", {32'd0, resp_hi}, {32'd0, e_hi});
            chk("hold_err", {63'd0, resp_err}, {63'd0, e_err});
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("consumed_valid", {63'd0, resp_valid}, 64'd0);
        chk("consumed_ready", {63'd0, req_ready}, 64'd1);
        chk("consumed_busy", {63'd0, busy}, 64'd0);
        hi  = resp_hi;
        lo  = resp_lo;
        err = resp_err;
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic        err;
        logic [4:0]  op;
        logic [31:0] a, b;

        clear      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 5'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_alu_opcode", {59'd0, alu_opcode}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_resp_lo", {32'd0, resp_lo}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        clear = 1'b1;
        @(posedge clock); #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

        run_op(5'b00011, 32'd7, 32'd5, 0, hi, lo, err);
        chk("add_lo_12", {32'd0, lo}, 64'd12);
        run_op(5'b10000, 32'h0001_0000, 32'h0001_0000, 0, hi, lo, err);
        chk("mul_hi_1", {32'd0, hi}, 64'd1);
        chk("mul_lo_0", {32'd0, lo}, 64'd0);
        run_op(5'b01111, 32'd100, 32'd0, 0, hi, lo, err);
        chk("div0_err", {63'd0, err}, 64'd1);
        run_op(5'b11111, 32'd1, 32'd2, 0, hi, lo, err);
        chk("illegal_err", {63'd0, err}, 64'd1);
        run_op(5'b00100, 32'd3, 32'd5, 5, hi, lo, err);
        chk("sub_lo", {32'd0, lo}, 64'hFFFF_FFFE);
        run_op(5'b01011, 32'd1, 32'd4, 0, hi, lo, err);
        chk("shl_lo_16", {32'd0, lo}, 64'd16);
        run_op(5'b10010, 32'd0, 32'd0, 0, hi, lo, err);
        chk("not_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("not_hi", {32'd0, hi}, 64'd0);
        run_op(5'b01111, 32'd100, 32'd7, 0, hi, lo, err);
        chk("div_q", {32'd0, lo}, 64'd14);
        chk("div_r", {32'd0, hi}, 64'd2);

        req_valid  = 1'b1;
        req_opcode = 5'b10000;
        req_a      = 32'hFFFF_FFFF;
        req_b      = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        chk("clr_alu_opcode", {59'd0, alu_opcode}, 64'd0);
        chk("clr_alu_a", {32'd0, alu_a}, 64'd0);
        chk("clr_alu_b", {32'd0, alu_b}, 64'd0);
        chk("clr_resp_hi", {32'd0, resp_hi}, 64'd0);
        chk("clr_resp_lo", {32'd0, resp_lo}, 64'd0);
        chk("clr_resp_err", {63'd0, resp_err}, 64'd0);
        chk("clr_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd0);
        @(posedge clock); #1;
        clear = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk("post_clr_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        run_op(5'b00011, 32'd1, 32'd1, 0, hi, lo, err);
        chk("post_clr_add", {32'd0, lo}, 64'd2);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            run_op(op, a, b, $urandom_range(0, 3), hi, lo, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
